// File: rtl/dmem_ctrl.sv
// Data-memory stage for the single-cycle core: byte-lane RAM, async read, sticky fault and access counter.
// Optional feature: define DMEM_ALIGN_CHECK_EN to treat misaligned half/word accesses as faults.
module dmem_ctrl #(
  parameter int          DEPTH = 2048,
  parameter int          AW    = 11,
  parameter logic [31:0] BASE  = 32'h10010000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_ena,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [2:0]  dm_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] acc_cnt
);

  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off_s;
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          access_s;
  logic          is_half_s;
  logic          is_byte_s;
  logic          align_fault_s;
  logic          ok_s;
  logic          fault_now_s;
  logic          we_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic [31:0]   word_s;

  logic          fault_d, fault_q;
  logic [31:0]   fault_addr_d, fault_addr_q;
  logic [31:0]   acc_cnt_d, acc_cnt_q;

  // Address decode and access classification
  always_comb begin
    off_s      = addr - BASE;
    in_range_s = (off_s < SPAN);
    idx_s      = off_s[AW+1:2];
    access_s   = dm_ena && (dm_r || dm_w);
    is_half_s  = 1'b0;
    is_byte_s  = 1'b0;
    case (dm_sel)
      3'b001:  is_half_s = 1'b1;
      3'b010:  is_byte_s = 1'b1;
      default: begin
        is_half_s = 1'b0;
        is_byte_s = 1'b0;
      end
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    if (is_half_s) begin
      align_fault_s = access_s && off_s[0];
    end else if (is_byte_s) begin
      align_fault_s = 1'b0;
    end else begin
      align_fault_s = access_s && (off_s[1:0] != 2'b00);
    end
`else
    align_fault_s = 1'b0;
`endif
    ok_s        = in_range_s && !align_fault_s;
    fault_now_s = access_s && !ok_s;
    we_s        = dm_ena && dm_w && ok_s;
  end

  assign word_s = mem[idx_s];

  // Same-cycle load data; a write this cycle is not yet visible
  always_comb begin
    rdata = 32'h0;
    if (dm_ena && dm_r && ok_s) begin
      if (is_half_s) begin
        rdata = {16'h0, off_s[1] ? word_s[31:16] : word_s[15:0]};
      end else if (is_byte_s) begin
        case (off_s[1:0])
          2'b00:   rdata = {24'h0, word_s[7:0]};
          2'b01:   rdata = {24'h0, word_s[15:8]};
          2'b10:   rdata = {24'h0, word_s[23:16]};
          default: rdata = {24'h0, word_s[31:24]};
        endcase
      end else begin
        rdata = word_s;
      end
    end else begin
      rdata = 32'h0;
    end
  end

  // Byte-lane enables and replicated store data
  always_comb begin
    be_s    = 4'b1111;
    wlane_s = wdata;
    if (is_half_s) begin
      be_s    = off_s[1] ? 4'b1100 : 4'b0011;
      wlane_s = {2{wdata[15:0]}};
    end else if (is_byte_s) begin
      be_s    = 4'b0001 << off_s[1:0];
      wlane_s = {4{wdata[7:0]}};
    end else begin
      be_s    = 4'b1111;
      wlane_s = wdata;
    end
  end

  // RAM write port; reset held at the edge blocks the pending store
  always_ff @(posedge clk) begin
    if (we_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  // First fault wins; clean accesses are counted
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    acc_cnt_d    = acc_cnt_q;
    if (fault_now_s) begin
      if (!fault_q) begin
        fault_d      = 1'b1;
        fault_addr_d = addr;
      end else begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
      end
    end else if (access_s) begin
      acc_cnt_d = acc_cnt_q + 32'd1;
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
  end

  // Debug status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      acc_cnt_q    <= 32'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      acc_cnt_q    <= acc_cnt_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign acc_cnt    = acc_cnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; expectations follow the macro DMEM_ALIGN_CHECK_EN.
module tb_dmem_ctrl;

  localparam logic [2:0] SW = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SB = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dm_ena = 1'b0;
  logic        dm_w = 1'b0;
  logic        dm_r = 1'b0;
  logic [2:0]  dm_sel = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] acc_cnt;

  int tests = 0;
  int errs  = 0;
  logic [31:0] rd;

  dmem_ctrl dut (
    .clk(clk), .reset(reset), .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r),
    .dm_sel(dm_sel), .addr(addr), .wdata(wdata), .rdata(rdata),
    .fault(fault), .fault_addr(fault_addr), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; rd holds rdata sampled at the falling edge.
  task automatic drive(input logic e, input logic w, input logic r, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    dm_ena = e; dm_w = w; dm_r = r; dm_sel = s; addr = a; wdata = d;
    @(negedge clk);
    rd = rdata;
    @(posedge clk);
    #1;
    dm_ena = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    tests++; if (fault !== 1'b0) begin errs++; $display("FAIL reset_fault: got %b expected 0", fault); end
    tests++; if (fault_addr !== 32'h0) begin errs++; $display("FAIL reset_faddr: got %h expected 0", fault_addr); end
    tests++; if (acc_cnt !== 32'h0) begin errs++; $display("FAIL reset_cnt: got %h expected 0", acc_cnt); end
    tests++; if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word;
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10010004, 32'h11223344);
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010004, 32'h0);
    tests++; if (rd !== 32'h11223344) begin errs++; $display("FAIL word_rd: got %h expected 11223344", rd); end
    tests++; if (acc_cnt !== 32'd2) begin errs++; $display("FAIL word_cnt: got %0d expected 2", acc_cnt); end
    tests++; if (fault !== 1'b0) begin errs++; $display("FAIL word_fault: got %b expected 0", fault); end
  endtask

  task automatic test_byte;
    drive(1'b1, 1'b1, 1'b0, SB, 32'h10010005, 32'h123456AA);
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010004, 32'h0);
    tests++; if (rd !== 32'h1122AA44) begin errs++; $display("FAIL byte_word: got %h expected 1122aa44", rd); end
    drive(1'b1, 1'b0, 1'b1, SB, 32'h10010007, 32'h0);
    tests++; if (rd !== 32'h00000011) begin errs++; $display("FAIL byte_lane3: got %h expected 00000011", rd); end
    drive(1'b1, 1'b0, 1'b1, SB, 32'h10010004, 32'h0);
    tests++; if (rd !== 32'h00000044) begin errs++; $display("FAIL byte_lane0: got %h expected 00000044", rd); end
  endtask

  task automatic test_half;
    drive(1'b1, 1'b1, 1'b0, SH, 32'h10010006, 32'h1234BEEF);
    drive(1'b1, 1'b0, 1'b1, SH, 32'h10010006, 32'h0);
    tests++; if (rd !== 32'h0000BEEF) begin errs++; $display("FAIL half_hi: got %h expected 0000beef", rd); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010004, 32'h0);
    tests++; if (rd !== 32'hBEEFAA44) begin errs++; $display("FAIL half_word: got %h expected beefaa44", rd); end
    drive(1'b1, 1'b0, 1'b1, SH, 32'h10010004, 32'h0);
    tests++; if (rd !== 32'h0000AA44) begin errs++; $display("FAIL half_lo: got %h expected 0000aa44", rd); end
    tests++; if (acc_cnt !== 32'd10) begin errs++; $display("FAIL half_cnt: got %0d expected 10", acc_cnt); end
  endtask

  task automatic test_same_cycle;
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10010010, 32'h00000077);
    drive(1'b1, 1'b1, 1'b1, SW, 32'h10010010, 32'h00000005);
    tests++; if (rd !== 32'h00000077) begin errs++; $display("FAIL same_old: got %h expected 00000077", rd); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010010, 32'h0);
    tests++; if (rd !== 32'h00000005) begin errs++; $display("FAIL same_new: got %h expected 00000005", rd); end
    drive(1'b0, 1'b0, 1'b1, SW, 32'h10010010, 32'h0);
    tests++; if (rd !== 32'h0) begin errs++; $display("FAIL noena_rd: got %h expected 0", rd); end
    tests++; if (acc_cnt !== 32'd13) begin errs++; $display("FAIL noena_cnt: got %0d expected 13", acc_cnt); end
  endtask

  task automatic test_out_of_range;
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10010000, 32'h01020304);
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10011FFC, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10011FFC, 32'h0);
    tests++; if (rd !== 32'hCAFEF00D) begin errs++; $display("FAIL last_word: got %h expected cafef00d", rd); end
    tests++; if (fault !== 1'b0) begin errs++; $display("FAIL last_fault: got %b expected 0", fault); end
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10012000, 32'hDEADBEEF);
    tests++; if (fault !== 1'b1) begin errs++; $display("FAIL oor_fault: got %b expected 1", fault); end
    tests++; if (fault_addr !== 32'h10012000) begin errs++; $display("FAIL oor_faddr: got %h expected 10012000", fault_addr); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h0FFFFFFC, 32'h0);
    tests++; if (rd !== 32'h0) begin errs++; $display("FAIL oor_rd: got %h expected 0", rd); end
    tests++; if (fault_addr !== 32'h10012000) begin errs++; $display("FAIL oor_first: got %h expected 10012000", fault_addr); end
    tests++; if (acc_cnt !== 32'd16) begin errs++; $display("FAIL oor_cnt: got %0d expected 16", acc_cnt); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010000, 32'h0);
    tests++; if (rd !== 32'h01020304) begin errs++; $display("FAIL oor_nowrite: got %h expected 01020304", rd); end
  endtask

  task automatic test_reset_mid;
    dm_ena = 1'b1; dm_w = 1'b1; dm_r = 1'b0; dm_sel = SW; addr = 32'h10010010; wdata = 32'h00000099;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    tests++; if (fault !== 1'b0) begin errs++; $display("FAIL rmid_fault: got %b expected 0", fault); end
    tests++; if (fault_addr !== 32'h0) begin errs++; $display("FAIL rmid_faddr: got %h expected 0", fault_addr); end
    tests++; if (acc_cnt !== 32'h0) begin errs++; $display("FAIL rmid_cnt: got %h expected 0", acc_cnt); end
    @(posedge clk); #1;
    dm_ena = 1'b0; dm_w = 1'b0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010010, 32'h0);
    tests++; if (rd !== 32'h00000005) begin errs++; $display("FAIL rmid_ram: got %h expected 00000005", rd); end
    tests++; if (acc_cnt !== 32'd1) begin errs++; $display("FAIL rmid_cnt1: got %0d expected 1", acc_cnt); end
  endtask

  task automatic test_align;
    logic [31:0] exp_mis, exp_w0, exp_faddr, exp_cnt;
    logic        exp_f;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_f = 1'b1; exp_faddr = 32'h10010002; exp_mis = 32'h0; exp_w0 = 32'h01020304; exp_cnt = 32'd2;
`else
    exp_f = 1'b0; exp_faddr = 32'h0; exp_mis = 32'hFFFFFFFF; exp_w0 = 32'hFFFFFFFF; exp_cnt = 32'd4;
`endif
    drive(1'b1, 1'b1, 1'b0, SW, 32'h10010002, 32'hFFFFFFFF);
    tests++; if (fault !== exp_f) begin errs++; $display("FAIL align_fault: got %b expected %b", fault, exp_f); end
    tests++; if (fault_addr !== exp_faddr) begin errs++; $display("FAIL align_faddr: got %h expected %h", fault_addr, exp_faddr); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010002, 32'h0);
    tests++; if (rd !== exp_mis) begin errs++; $display("FAIL align_rd: got %h expected %h", rd, exp_mis); end
    drive(1'b1, 1'b0, 1'b1, SW, 32'h10010000, 32'h0);
    tests++; if (rd !== exp_w0) begin errs++; $display("FAIL align_word0: got %h expected %h", rd, exp_w0); end
    tests++; if (acc_cnt !== exp_cnt) begin errs++; $display("FAIL align_cnt: got %0d expected %0d", acc_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
